fan_tach: RTL and testbench
===========================

FAN_TACH -- requirements
Module: fan_tach

Interface
REQ-001 The block SHALL have parameter CntWidth, default 24, giving the width of the period and window counters.
REQ-002 The block SHALL have parameter PulseWidth, default 16, giving the width of the pulse counter.
REQ-003 The block SHALL have parameter DebounceCycles, default 16, giving the number of stable cycles required to accept a tach level.
REQ-004 The block SHALL have parameter WindowCycles, default 20_000_000, giving the measurement window length (1 s at the 20 MHz soc_clk).
REQ-005 The block SHALL have parameter TimeoutCycles, default 10_000_000, giving the maximum cycles without an edge before a stall is flagged.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port enable_i, input, 1 bit: measurement enable.
REQ-009 The block SHALL have port tach_i, input, 1 bit: asynchronous open-drain fan tach line, active-low pulses.
REQ-010 The block SHALL have port pulses_o, output, PulseWidth bits: falling-edge count of the last completed window.
REQ-011 The block SHALL have port period_o, output, CntWidth bits: cycles between the last two accepted falling edges.
REQ-012 The block SHALL have port valid_o, output, 1 bit: one-cycle strobe at each window close.
REQ-013 The block SHALL have port stall_o, output, 1 bit: level, high while no edge has been seen for TimeoutCycles.

Function
REQ-014 tach_i SHALL pass through a 2-flop synchronizer before any use.
REQ-015 The debounced level SHALL change only after the synchronized level differs from it for DebounceCycles consecutive cycles; any reversion restarts the count.
REQ-016 An accepted falling edge SHALL be the debounced level going 1->0; latency from a tach_i step to the accepted edge SHALL be 2+DebounceCycles cycles.
REQ-017 The FSM SHALL have states IDLE, FIRST and MEASURE.
REQ-018 In IDLE, all counters SHALL hold at 0 and the outputs SHALL hold their values; when enable_i=1 the FSM SHALL go to FIRST.
REQ-019 In FIRST, the window counter and timeout SHALL run; the first accepted edge SHALL zero the period counter, increment the pulse counter and move the FSM to MEASURE, with period_o unchanged.
REQ-020 In MEASURE, each accepted edge SHALL load period_o with the period counter +1, restart the period counter at 0 and increment the pulse counter.
REQ-021 The pulse counter SHALL saturate at all-ones; the period counter SHALL saturate at all-ones.
REQ-022 When the window counter reaches WindowCycles-1, the block SHALL load pulses_o with the pulse count, including an edge accepted in that same cycle; it SHALL assert valid_o for one cycle and restart the window and pulse counters at 0.
REQ-023 When the period counter reaches TimeoutCycles, stall_o SHALL go to 1, period_o SHALL load all-ones and the FSM SHALL return to FIRST.
REQ-024 stall_o SHALL clear on the next accepted edge.
REQ-025 When enable_i goes to 0 in any state, the FSM SHALL go to IDLE on the next cycle, a partial window SHALL be discarded, valid_o SHALL not be asserted and stall_o SHALL clear.
REQ-026 The debouncer SHALL keep running while disabled, so no false edge occurs on re-enable.

Reset
REQ-027 When rst_i=1 at a clk_i edge, the FSM SHALL go to IDLE and all counters and synchronizer flops SHALL clear.
REQ-028 On the same reset, pulses_o, period_o, valid_o and stall_o SHALL be 0.
REQ-029 The debounced level SHALL reset to 1, the line idle-high value.
REQ-030 Reset SHALL take priority over every other event, including window close and timeout in the same cycle.

Structure
REQ-031 The FSM state enum and default width constants SHALL live in a shared package fan_pkg, which the existing fan PWM controller SHALL also import.
REQ-032 The synchronizer and debouncer SHALL be one sub-module, tach_debounce, with ports clk_i, rst_i, d_i, q_o and fall_o.
REQ-033 The counters and FSM SHALL be in fan_tach.

Verification (bench parameters: WindowCycles=1000, DebounceCycles=4, TimeoutCycles=500, CntWidth=16)
REQ-034 Square wave with period 100 cycles, enabled -> valid_o every 1000 cycles; pulses_o=10 from the second window; period_o=100.
REQ-035 2-cycle glitches on tach_i superimposed on the 100-cycle wave -> pulses_o=10 and period_o=100, unchanged by the glitches.
REQ-036 Tach line stopped low after one edge -> stall_o=1 and period_o=0xFFFF 500 cycles after that edge; the next edge clears stall_o and period_o is unchanged.
REQ-037 An edge accepted exactly in the window-close cycle -> it is counted in the closing pulses_o and the new window starts at 0.
REQ-038 enable_i dropped at cycle 600 of a window, then re-raised -> no valid_o for the partial window; the next valid_o comes 1000 cycles after re-enable.
REQ-039 rst_i asserted during MEASURE at the window-close cycle -> the next cycle has all outputs 0 and no valid_o pulse.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan-control types and default sizing, used by the tach monitor and the PWM controller.
package fan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRST   = 2'd1,
    ST_MEASURE = 2'd2
  } tach_state_t;

  localparam int DEF_CNT_WIDTH       = 24;
  localparam int DEF_PULSE_WIDTH     = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_WINDOW_CYCLES   = 20_000_000;
  localparam int DEF_TIMEOUT_CYCLES  = 10_000_000;

endpackage

// File: rtl/tach_debounce.sv
// Two-flop synchronizer plus debouncer for the open-drain tach line; fall_o pulses one cycle
// when the debounced level drops, 2+DebounceCycles cycles after a clean input step.
module tach_debounce #(
  parameter int DebounceCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  localparam int DW = $clog2(DebounceCycles + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] stable_cnt;
  logic          flip;

  assign flip = (sync2 != q_o) && (stable_cnt == DW'(DebounceCycles - 1));

  // Debounced level resets high: the line idles high through its pull-up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      q_o        <= 1'b1;
      stable_cnt <= '0;
      fall_o     <= 1'b0;
    end else begin
      sync1  <= d_i;
      sync2  <= sync1;
      fall_o <= flip && !sync2;
      if (sync2 == q_o) begin
        stable_cnt <= '0;
      end else if (flip) begin
        q_o        <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_tach.sv
// Fan tachometer: per-window falling-edge count, edge-to-edge period and stall detection.
// All outputs registered; valid_o strobes once per completed window.
module fan_tach
  import fan_pkg::*;
#(
  parameter int CntWidth       = DEF_CNT_WIDTH,
  parameter int PulseWidth     = DEF_PULSE_WIDTH,
  parameter int DebounceCycles = DEF_DEBOUNCE_CYCLES,
  parameter int WindowCycles   = DEF_WINDOW_CYCLES,
  parameter int TimeoutCycles  = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  tach_i,
  output logic [PulseWidth-1:0] pulses_o,
  output logic [CntWidth-1:0]   period_o,
  output logic                  valid_o,
  output logic                  stall_o
);

  tach_state_t           state;
  tach_state_t           state_next;
  logic                  fall;
  logic                  deb_level;
  logic                  running;
  logic                  edge_ok;
  logic                  win_close;
  logic                  timeout;
  logic [CntWidth-1:0]   win_cnt;
  logic [CntWidth-1:0]   per_cnt;
  logic [CntWidth-1:0]   period_meas;
  logic [PulseWidth-1:0] pulse_cnt;
  logic [PulseWidth-1:0] pulse_inc;

  tach_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (tach_i),
    .q_o    (deb_level),
    .fall_o (fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (enable_i) state_next = ST_FIRST;
      ST_FIRST: begin
        if (!enable_i)    state_next = ST_IDLE;
        else if (edge_ok) state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable_i)    state_next = ST_IDLE;
        else if (timeout) state_next = ST_FIRST;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // An edge wins over a coincident timeout: it proves the fan is still turning.
  always_comb begin
    running     = enable_i && (state != ST_IDLE);
    edge_ok     = running && fall && !deb_level;
    win_close   = running && (win_cnt == CntWidth'(WindowCycles - 1));
    timeout     = running && !edge_ok && (per_cnt == CntWidth'(TimeoutCycles));
    pulse_inc   = (edge_ok && (pulse_cnt != '1)) ? pulse_cnt + 1'b1 : pulse_cnt;
    period_meas = (per_cnt != '1) ? per_cnt + 1'b1 : per_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_cnt   <= '0;
      per_cnt   <= '0;
      pulse_cnt <= '0;
      pulses_o  <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      stall_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!running) begin
        win_cnt   <= '0;
        per_cnt   <= '0;
        pulse_cnt <= '0;
        stall_o   <= 1'b0;
      end else begin
        if (win_close) begin
          pulses_o  <= pulse_inc;
          valid_o   <= 1'b1;
          win_cnt   <= '0;
          pulse_cnt <= '0;
        end else begin
          win_cnt   <= win_cnt + 1'b1;
          pulse_cnt <= pulse_inc;
        end
        // The first edge after (re)start only anchors the period counter.
        if (edge_ok) begin
          per_cnt <= '0;
          stall_o <= 1'b0;
          if (state == ST_MEASURE) period_o <= period_meas;
        end else if (timeout) begin
          stall_o  <= 1'b1;
          period_o <= '1;
          per_cnt  <= '0;
        end else if (per_cnt != '1) begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fan_tach.sv
// Randomized and directed stimulus for fan_tach, checked against a cycle-level behavioural model.
module tb_fan_tach;

  localparam int CW   = 16;
  localparam int PW   = 16;
  localparam int DB   = 4;
  localparam int WIN  = 1000;
  localparam int TO   = 500;
  localparam int PMAX = (1 << PW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          tach_i;
  logic [PW-1:0] pulses_o;
  logic [CW-1:0] period_o;
  logic          valid_o;
  logic          stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fan_tach #(
    .CntWidth       (CW),
    .PulseWidth     (PW),
    .DebounceCycles (DB),
    .WindowCycles   (WIN),
    .TimeoutCycles  (TO)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .tach_i   (tach_i),
    .pulses_o (pulses_o),
    .period_o (period_o),
    .valid_o  (valid_o),
    .stall_o  (stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit t_d1, t_d2, r_d1, r_d2;
  bit m_deb, m_fall;
  bit dq[$];
  int m_mode, m_win, m_per, m_pc;
  int e_pulses, e_period;
  bit e_valid, e_stall;

  // One clock edge of the model: the debounced level follows the input seen two edges
  // late once the last DB samples all disagree with it; the fall it produces is acted on
  // by the measurement logic one edge later.
  task automatic model_step(input bit rst, input bit en, input bit tach);
    bit seen, fall_in, all_opp;
    seen    = (r_d1 || r_d2) ? 1'b0 : t_d2;
    fall_in = m_fall;
    if (rst) begin
      m_deb  = 1'b1;
      m_fall = 1'b0;
      dq.delete();
    end else begin
      dq.push_back(seen);
      if (dq.size() > DB) void'(dq.pop_front());
      all_opp = (dq.size() == DB);
      foreach (dq[i]) if (dq[i] == m_deb) all_opp = 1'b0;
      m_fall = all_opp && m_deb;
      if (all_opp) begin
        m_deb = !m_deb;
        dq.delete();
      end
    end
    if (rst) begin
      m_mode = 0; m_win = 0; m_per = 0; m_pc = 0;
      e_pulses = 0; e_period = 0; e_valid = 1'b0; e_stall = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (m_mode == 0 || !en) begin
        m_mode = (m_mode == 0 && en) ? 1 : 0;
        m_win = 0; m_per = 0; m_pc = 0;
        e_stall = 1'b0;
      end else begin
        if (fall_in && m_pc < PMAX) m_pc++;
        if (m_win == WIN - 1) begin
          e_pulses = m_pc; e_valid = 1'b1; m_win = 0; m_pc = 0;
        end else begin
          m_win++;
        end
        if (fall_in) begin
          if (m_mode == 2) e_period = (m_per < CMAX) ? m_per + 1 : CMAX;
          m_per = 0; e_stall = 1'b0; m_mode = 2;
        end else if (m_per == TO) begin
          e_stall = 1'b1; e_period = CMAX; m_per = 0; m_mode = 1;
        end else if (m_per < CMAX) begin
          m_per++;
        end
      end
    end
    t_d2 = t_d1; t_d1 = tach; r_d2 = r_d1; r_d1 = rst;
  endtask

  task automatic step(input bit rst, input bit en, input bit tach);
    logic [63:0] got, exp;
    rst_i = rst; enable_i = en; tach_i = tach;
    @(posedge clk_i);
    model_step(rst, en, tach);
    #1;
    got = {30'd0, valid_o, stall_o, pulses_o, period_o};
    exp = {30'd0, e_valid, e_stall, e_pulses[PW-1:0], e_period[CW-1:0]};
    chk("outs", got, exp);
  endtask

  function automatic bit sq(input int ph, input int p);
    return (ph % p) < (p / 2);
  endfunction

  initial begin
    int ph, nvalid, last_v, vcount, g1, g2, p, seg, dis, gl;
    bit t, en, r;
    t_d1 = 1'b1; t_d2 = 1'b1; r_d1 = 1'b1; r_d2 = 1'b1; m_deb = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    chk("rst_pulses", pulses_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_stall", stall_o, 0);

    // Clean 100-cycle wave.
    ph = 0; nvalid = 0; last_v = 0;
    for (int i = 0; i < 3100; i++) begin
      step(1'b0, 1'b1, sq(ph, 100)); ph++;
      if (valid_o) begin
        nvalid++;
        if (nvalid >= 2) begin
          chk("win_pulses", pulses_o, 10);
          chk("valid_gap", i - last_v, WIN);
        end
        last_v = i;
      end
    end
    chk("sq_valids", nvalid, 3);
    chk("sq_period", period_o, 100);

    // Same wave with 2-cycle glitches inside each half period.
    g1 = 20; g2 = 70;
    for (int i = 0; i < 2100; i++) begin
      if (ph % 100 == 0) begin
        g1 = $urandom_range(8, 38);
        g2 = $urandom_range(58, 88);
      end
      t = sq(ph, 100);
      if ((ph % 100) == g1 || (ph % 100) == g1 + 1 || (ph % 100) == g2 || (ph % 100) == g2 + 1) t = !t;
      step(1'b0, 1'b1, t); ph++;
      if (valid_o) chk("glitch_pulses", pulses_o, 10);
    end
    chk("glitch_period", period_o, 100);

    // Line stops low after one edge.
    while (ph % 100 != 0) begin step(1'b0, 1'b1, sq(ph, 100)); ph++; end
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == DB + 502) chk("stall_early", stall_o, 0);
      if (i == DB + 503) begin
        chk("stall_set", stall_o, 1);
        chk("stall_period", period_o, 16'hFFFF);
      end
    end
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    chk("stall_clear", stall_o, 0);
    chk("period_keep", period_o, 16'hFFFF);

    // Edge accepted in the window-close cycle.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 2 * WIN; i++) begin
      step(1'b0, 1'b1, (i >= WIN - 2 - DB) ? 1'b0 : 1'b1);
      if (i == WIN) begin
        chk("close_valid", valid_o, 1);
        chk("close_pulses", pulses_o, 1);
      end
      if (i == 2 * WIN) begin
        chk("next_valid", valid_o, 1);
        chk("next_pulses", pulses_o, 0);
        chk("next_stall", stall_o, 1);
      end
    end

    // Enable dropped mid-window.
    ph = 0;
    step(1'b0, 1'b0, sq(ph, 100)); ph++;
    chk("disable_stall", stall_o, 0);
    for (int i = 0; i < 9; i++) begin step(1'b0, 1'b0, sq(ph, 100)); ph++; end
    vcount = 0;
    for (int i = 0; i <= 620 + WIN; i++) begin
      en = !(i >= 600 && i < 620);
      step(1'b0, en, sq(ph, 100)); ph++;
      if (i < 620 + WIN && valid_o) vcount++;
      if (i == 620 + WIN) chk("reenable_valid", valid_o, 1);
    end
    chk("partial_discarded", vcount, 0);

    // Reset lands on the window-close cycle while measuring.
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0, sq(ph, 100)); ph++; end
    for (int i = 0; i <= WIN; i++) begin step(i == WIN, 1'b1, sq(ph, 100)); ph++; end
    chk("rstclose_valid", valid_o, 0);
    chk("rstclose_pulses", pulses_o, 0);
    chk("rstclose_period", period_o, 0);
    chk("rstclose_stall", stall_o, 0);
    step(1'b0, 1'b1, sq(ph, 100)); ph++;
    chk("post_rst_valid", valid_o, 0);

    // Random speeds, glitches, enable drops and occasional resets.
    seg = 0; dis = 0; gl = 0; p = 100;
    for (int i = 0; i < 8000; i++) begin
      if (seg == 0) begin
        p = $urandom_range(30, 1300);
        seg = $urandom_range(500, 1500);
        ph = 0;
      end
      seg--;
      t = sq(ph, p); ph++;
      if (gl > 0) begin
        t = !t; gl--;
      end else if ($urandom_range(0, 99) < 3) begin
        gl = $urandom_range(1, 3);
      end
      if (dis > 0) dis--;
      else if ($urandom_range(0, 999) < 2) dis = $urandom_range(5, 60);
      en = (dis == 0);
      r  = ($urandom_range(0, 1999) == 0);
      step(r, en, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
